// File: rtl/kernel2_prod_acc.sv
`default_nettype none
// ============================================================================
// Module   : kernel2_prod_acc
// Purpose  : Accumulates a run of LEN unsigned kernel2 products into one sum
//            and returns it on a registered valid/ready output.
// Options  : KERNEL2_ACC_SAT_EN - saturating accumulate with sticky overflow flag
// Revision : 1.0 - initial release
// ============================================================================
module kernel2_prod_acc #(
  parameter int PROD_W = 22,
  parameter int ACC_W  = 32,
  parameter int CNT_W  = 8
) (
  input  logic              ap_clk,
  input  logic              ap_rst_n,
  input  logic              start,
  input  logic [CNT_W-1:0]  len,
  output logic              busy,
  input  logic [PROD_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [ACC_W-1:0]  out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_ovf
);

  generate
    if (ACC_W < PROD_W) begin : g_bad_width
      $error("kernel2_prod_acc: ACC_W must be >= PROD_W");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [ACC_W-1:0]  out_data_q, out_data_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ACC_W-1:0]  acc_next;
  logic              beat;

`ifdef KERNEL2_ACC_SAT_EN
  logic              ovf_q, ovf_d;
  logic              out_ovf_q, out_ovf_d;
  logic              ovf_next;
  logic [ACC_W:0]    sum_wide;

  // The carry out of the widened add is the true-result >= 2^ACC_W condition.
  always_comb begin
    sum_wide = {1'b0, acc_q} + (ACC_W+1)'(in_data);
    if (sum_wide[ACC_W]) begin
      acc_next = '1;
      ovf_next = 1'b1;
    end else begin
      acc_next = sum_wide[ACC_W-1:0];
      ovf_next = ovf_q;
    end
  end
`else
  assign acc_next = acc_q + ACC_W'(in_data);
`endif

  // Handshake outputs decode the state register only.
  assign busy      = (state_q != S_IDLE);
  assign in_ready  = (state_q == S_ACC);
  assign out_valid = (state_q == S_HOLD);
  assign out_data  = out_data_q;
  assign beat      = in_valid & in_ready;

`ifdef KERNEL2_ACC_SAT_EN
  assign out_ovf = out_ovf_q;
`else
  assign out_ovf = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    out_data_d = out_data_q;
`ifdef KERNEL2_ACC_SAT_EN
    ovf_d      = ovf_q;
    out_ovf_d  = out_ovf_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (len == '0) begin
            out_data_d = '0;
`ifdef KERNEL2_ACC_SAT_EN
            out_ovf_d  = 1'b0;
`endif
            state_d    = S_HOLD;
          end else begin
            acc_d   = '0;
            cnt_d   = len;
`ifdef KERNEL2_ACC_SAT_EN
            ovf_d   = 1'b0;
`endif
            state_d = S_ACC;
          end
        end
      end
      S_ACC: begin
        if (beat) begin
          acc_d = acc_next;
          cnt_d = cnt_q - CNT_W'(1);
`ifdef KERNEL2_ACC_SAT_EN
          ovf_d = ovf_next;
`endif
          if (cnt_q == CNT_W'(1)) begin
            out_data_d = acc_next;
`ifdef KERNEL2_ACC_SAT_EN
            out_ovf_d  = ovf_next;
`endif
            state_d    = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q    <= S_IDLE;
      acc_q      <= '0;
      cnt_q      <= '0;
      out_data_q <= '0;
`ifdef KERNEL2_ACC_SAT_EN
      ovf_q      <= 1'b0;
      out_ovf_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      out_data_q <= out_data_d;
`ifdef KERNEL2_ACC_SAT_EN
      ovf_q      <= ovf_d;
      out_ovf_q  <= out_ovf_d;
`endif
    end
  end

endmodule
`default_nettype wire
